mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl.sv | 108 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a downstream 4:1 mux: latches a word, walks the select
// through 0..3, captures the mux output for each, and reports the rebuilt word.
module mux_scan_ctrl #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] din,
    input  logic       mux_q,
    output logic [3:0] mux_d,
    output logic [1:0] mux_sel,
    output logic       busy,
    output logic       done,
    output logic [3:0] dout,
    output logic       mismatch
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] data_q, data_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cap_q, cap_d;
    logic [3:0] dout_q, dout_d;
    logic       mismatch_q, mismatch_d;

    // NOTE: every _d gets its hold value first so no path through the case leaves a latch.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        cap_d      = cap_q;
        dout_d     = dout_q;
        mismatch_d = mismatch_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d     = din;
                    sel_d      = 2'd0;
                    cnt_d      = 4'd0;
                    cap_d      = 4'd0;
                    mismatch_d = 1'b0;
                    state_d    = SCAN;
                end
            end

            SCAN: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d        = 4'd0;
                    cap_d[sel_q] = mux_q;
                    // The final capture feeds dout directly, so it must read the updated cap_d.
                    if (sel_q == 2'd3) begin
                        dout_d     = cap_d;
                        mismatch_d = (cap_d != data_q);
                        state_d    = DONE;
                    end else begin
                        sel_d = sel_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            data_q     <= 4'd0;
            sel_q      <= 2'd0;
            cnt_q      <= 4'd0;
            cap_q      <= 4'd0;
            dout_q     <= 4'd0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
            dout_q     <= dout_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign mux_d    = data_q;
    assign mux_sel  = sel_q;
    assign busy     = (state_q == SCAN);
    assign done     = (state_q == DONE);
    assign dout     = dout_q;
    assign mismatch = mismatch_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: one instance with HOLD_CYCLES=1 and one
// with HOLD_CYCLES=3, each driving a behavioural 4:1 mux that can be stuck at 0.
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start1 = 1'b0, stuck1 = 1'b0;
    logic [3:0] din1 = 4'd0;
    logic       mux_q1;
    logic [3:0] mux_d1, dout1;
    logic [1:0] mux_sel1;
    logic       busy1, done1, mismatch1;

    logic       start3 = 1'b0;
    logic [3:0] din3 = 4'd0;
    logic       mux_q3;
    logic [3:0] mux_d3, dout3;
    logic [1:0] mux_sel3;
    logic       busy3, done3, mismatch3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mux_q1 = stuck1 ? 1'b0 : mux_d1[mux_sel1];
    assign mux_q3 = mux_d3[mux_sel3];

    mux_scan_ctrl #(.HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .din(din1), .mux_q(mux_q1),
        .mux_d(mux_d1), .mux_sel(mux_sel1), .busy(busy1), .done(done1),
        .dout(dout1), .mismatch(mismatch1)
    );

    mux_scan_ctrl #(.HOLD_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .din(din3), .mux_q(mux_q3),
        .mux_d(mux_d3), .mux_sel(mux_sel3), .busy(busy3), .done(done3),
        .dout(dout3), .mismatch(mismatch3)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero1(input string tag);
        check({tag, " mux_d"}, {4'd0, mux_d1}, 8'h00);
        check({tag, " mux_sel"}, {6'd0, mux_sel1}, 8'h00);
        check({tag, " busy"}, {7'd0, busy1}, 8'h00);
        check({tag, " done"}, {7'd0, done1}, 8'h00);
        check({tag, " dout"}, {4'd0, dout1}, 8'h00);
        check({tag, " mismatch"}, {7'd0, mismatch1}, 8'h00);
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;

        // Reset state, observed before any clock edge.
        #1;
        check_zero1("reset");
        check("reset dout3", {4'd0, dout3}, 8'h00);
        check("reset busy3", {7'd0, busy3}, 8'h00);
        #1 rst_n = 1'b1;

        // Good mux, din=0011: sel steps 0..3, done on the 4th edge after accept.
        din1 = 4'b0011; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("t1 busy", {7'd0, busy1}, 8'h01);
        check("t1 mux_d", {4'd0, mux_d1}, 8'h03);
        check("t1 sel0", {6'd0, mux_sel1}, 8'h00);
        tick(); check("t1 sel1", {6'd0, mux_sel1}, 8'h01);
        check("t1 no early done", {7'd0, done1}, 8'h00);
        tick(); check("t1 sel2", {6'd0, mux_sel1}, 8'h02);
        tick(); check("t1 sel3", {6'd0, mux_sel1}, 8'h03);
        check("t1 dout before done", {4'd0, dout1}, 8'h00);
        tick();
        check("t1 done", {7'd0, done1}, 8'h01);
        check("t1 busy low", {7'd0, busy1}, 8'h00);
        check("t1 dout", {4'd0, dout1}, 8'h03);
        check("t1 mismatch", {7'd0, mismatch1}, 8'h00);
        check("t1 sel held", {6'd0, mux_sel1}, 8'h03);
        tick();
        check("t1 done pulse ends", {7'd0, done1}, 8'h00);
        check("t1 idle dout hold", {4'd0, dout1}, 8'h03);
        tick();
        check("t1 idle sel hold", {6'd0, mux_sel1}, 8'h03);
        check("t1 idle mux_d hold", {4'd0, mux_d1}, 8'h03);

        // Mux stuck at 0, din=1010 -> dout=0000, mismatch=1.
        stuck1 = 1'b1; din1 = 4'b1010; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (3) tick();
        tick();
        check("t2 done", {7'd0, done1}, 8'h01);
        check("t2 dout", {4'd0, dout1}, 8'h00);
        check("t2 mismatch", {7'd0, mismatch1}, 8'h01);
        tick();
        check("t2 mismatch hold", {7'd0, mismatch1}, 8'h01);
        // Same stuck mux, din=0000 -> no mismatch.
        din1 = 4'b0000; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (4) tick();
        check("t2b done", {7'd0, done1}, 8'h01);
        check("t2b dout", {4'd0, dout1}, 8'h00);
        check("t2b mismatch", {7'd0, mismatch1}, 8'h00);
        stuck1 = 1'b0;
        tick();

        // start held through SCAN and DONE is ignored; accepted in the next IDLE cycle.
        din1 = 4'b1001; start1 = 1'b1;
        tick();
        din1 = 4'b0101;
        repeat (3) tick();
        check("t3 mux_d unchanged", {4'd0, mux_d1}, 8'h09);
        tick();
        check("t3 done", {7'd0, done1}, 8'h01);
        check("t3 dout original", {4'd0, dout1}, 8'h09);
        tick();
        check("t3 done ignored start", {7'd0, busy1}, 8'h00);
        check("t3 idle mux_d", {4'd0, mux_d1}, 8'h09);
        tick();
        start1 = 1'b0;
        check("t3 accept busy", {7'd0, busy1}, 8'h01);
        check("t3 accept mux_d", {4'd0, mux_d1}, 8'h05);
        repeat (4) tick();
        check("t3b done", {7'd0, done1}, 8'h01);
        check("t3b dout", {4'd0, dout1}, 8'h05);
        tick();

        // Asynchronous reset at mux_sel=2 aborts the scan.
        din1 = 4'b0110; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick(); tick();
        check("t4 sel2", {6'd0, mux_sel1}, 8'h02);
        #2 rst_n = 1'b0;
        #1;
        check_zero1("t4 async");
        done_cnt = 0;
        repeat (2) begin
            tick();
            if (done1) done_cnt++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            if (done1) done_cnt++;
        end
        check("t4 no done pulse", 8'(done_cnt), 8'h00);
        // The first edge after release accepts start.
        din1 = 4'b1111; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("t4 accept busy", {7'd0, busy1}, 8'h01);
        repeat (4) tick();
        check("t4 done", {7'd0, done1}, 8'h01);
        check("t4 dout", {4'd0, dout1}, 8'h0f);
        check("t4 mismatch", {7'd0, mismatch1}, 8'h00);

        // HOLD_CYCLES=3, din=1100: sel held 3 cycles each, busy 12 cycles, done on edge 12.
        din3 = 4'b1100; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        busy_cnt = busy3 ? 1 : 0;
        done_cnt = 0;
        for (int k = 1; k < 12; k++) begin
            tick();
            check($sformatf("t5 sel k=%0d", k), {6'd0, mux_sel3}, 8'(k / 3));
            if (busy3) busy_cnt++;
            if (done3) done_cnt++;
        end
        check("t5 no early done", 8'(done_cnt), 8'h00);
        check("t5 busy cycles", 8'(busy_cnt), 8'd12);
        tick();
        check("t5 done edge12", {7'd0, done3}, 8'h01);
        check("t5 busy low", {7'd0, busy3}, 8'h00);
        check("t5 dout", {4'd0, dout3}, 8'h0c);
        check("t5 mismatch", {7'd0, mismatch3}, 8'h00);
        tick();
        check("t5 done ends", {7'd0, done3}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
